cc_miss_req_scheduler: RTL and testbench

Sequences cache-line refills for the cache controller: accepts one miss at a time from the hit/miss logic, issues the AXI read-address burst to memory, and pushes the same miss address into the miss-address FIFO. The data fill unit pops that FIFO to deserialize the returning R beats. The scheduler bounds the number of in-flight refills and keeps AR issue order identical to FIFO order, so each R burst pairs with the correct FIFO entry.

---
 rtl/cc_pkg.sv | 11 +
 rtl/cc_outstanding_counter.sv | 47 ++++
 rtl/cc_miss_req_scheduler.sv | 82 ++++++++
 tb/tb_cc_miss_req_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// cc_pkg: shared types and AXI constants for the cache controller refill path
package cc_pkg;

    typedef enum logic {IDLE, ISSUE} state_e;

    localparam int          CC_LINE_OFF_W = 6;
    localparam logic [3:0]  CC_ARLEN      = 4'((1 << (CC_LINE_OFF_W - 3)) - 1);
    localparam logic [2:0]  CC_ARSIZE     = 3'd3;
    localparam logic [1:0]  CC_BURST_WRAP = 2'b10;

endpackage

// File: rtl/cc_outstanding_counter.sv
// cc_outstanding_counter: in-flight refill count with underflow detection
module cc_outstanding_counter #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // inc and dec together cancel; a dec at zero saturates and flags a stray RLAST
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i)
            cnt_d = cnt_q + CNT_W'(1);
        else if (dec_i && !inc_i) begin
            if (cnt_q == '0)
                err_d = 1'b1;
            else
                cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // count and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = cnt_q >= CNT_W'(MAX);
    assign err_o  = err_q;

endmodule

// File: rtl/cc_miss_req_scheduler.sv
// cc_miss_req_scheduler: issues AXI refill bursts and pushes miss addresses in AR order
module cc_miss_req_scheduler
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_req_i,
    input  logic [31:0]      miss_addr_i,
    output logic             miss_ack_o,
    output logic             mem_arvalid_o,
    input  logic             mem_arready_i,
    output logic [31:0]      mem_araddr_o,
    output logic [3:0]       mem_arlen_o,
    output logic [2:0]       mem_arsize_o,
    output logic [1:0]       mem_arburst_o,
    input  logic             mem_rvalid_i,
    input  logic             mem_rready_i,
    input  logic             mem_rlast_i,
    input  logic             miss_addr_fifo_full_i,
    output logic             miss_addr_fifo_wren_o,
    output logic [31:0]      miss_addr_fifo_wdata_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o,
    output logic             err_o
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        ar_hs, cnt_full;

    assign ar_hs = (state_q == ISSUE) && mem_arready_i;

    // accept a miss only when a slot and FIFO room exist; return to IDLE on AR handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == IDLE && miss_req_i && !cnt_full && !miss_addr_fifo_full_i) begin
            state_d = ISSUE;
            addr_d  = miss_addr_i;
        end
        if (ar_hs)
            state_d = IDLE;
    end

    // state and latched miss address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    cc_outstanding_counter #(
        .MAX   (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (ar_hs),
        .dec_i  (mem_rvalid_i && mem_rready_i && mem_rlast_i),
        .cnt_o  (outstanding_o),
        .full_o (cnt_full),
        .err_o  (err_o)
    );

    assign mem_arvalid_o          = state_q == ISSUE;
    assign mem_araddr_o           = {addr_q[31:3], 3'b000};
    assign mem_arlen_o            = CC_ARLEN;
    assign mem_arsize_o           = CC_ARSIZE;
    assign mem_arburst_o          = CC_BURST_WRAP;
    assign miss_ack_o             = ar_hs;
    assign miss_addr_fifo_wren_o  = ar_hs;
    assign miss_addr_fifo_wdata_o = addr_q;
    assign busy_o                 = (state_q != IDLE) || (outstanding_o != '0);

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// tb_cc_miss_req_scheduler: scoreboard bench for the refill scheduler
module tb_cc_miss_req_scheduler;

    localparam int MAX   = 4;
    localparam int CNT_W = $clog2(MAX + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             miss_req_i;
    logic [31:0]      miss_addr_i;
    logic             miss_ack_o;
    logic             mem_arvalid_o;
    logic             mem_arready_i;
    logic [31:0]      mem_araddr_o;
    logic [3:0]       mem_arlen_o;
    logic [2:0]       mem_arsize_o;
    logic [1:0]       mem_arburst_o;
    logic             mem_rvalid_i;
    logic             mem_rready_i;
    logic             mem_rlast_i;
    logic             miss_addr_fifo_full_i;
    logic             miss_addr_fifo_wren_o;
    logic [31:0]      miss_addr_fifo_wdata_o;
    logic [CNT_W-1:0] outstanding_o;
    logic             busy_o;
    logic             err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cc_miss_req_scheduler #(.MAX_OUTSTANDING(MAX)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_req_i             (miss_req_i),
        .miss_addr_i            (miss_addr_i),
        .miss_ack_o             (miss_ack_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_i           (mem_rready_i),
        .mem_rlast_i            (mem_rlast_i),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .outstanding_o          (outstanding_o),
        .busy_o                 (busy_o),
        .err_o                  (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_r(input logic v);
        mem_rvalid_i = v;
        mem_rready_i = v;
        mem_rlast_i  = v;
    endtask

    task automatic rlast_pulse();
        set_r(1'b1);
        tick();
        set_r(1'b0);
    endtask

    task automatic issue(input logic [31:0] a);
        miss_req_i  = 1'b1;
        miss_addr_i = a;
        exp_q.push_back(a);
        tick();
        chk("iss_ack", miss_ack_o, 1);
        tick();
        miss_req_i = 1'b0;
    endtask

    // scoreboard: every FIFO push must match the oldest issued miss, with AR alongside
    always @(negedge clk) begin
        if (rst_n && miss_addr_fifo_wren_o) begin
            chk("ack_with_push", miss_ack_o, 1);
            if (exp_q.size() == 0)
                chk("unexpected_push", miss_addr_fifo_wdata_o, 32'hxxxx_xxxx);
            else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("fifo_wdata", miss_addr_fifo_wdata_o, e);
                chk("ar_addr_at_push", mem_araddr_o, {e[31:3], 3'b000});
                chk("arvalid_at_push", mem_arvalid_o, 1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        miss_req_i = 1'b0;
        miss_addr_i = '0;
        mem_arready_i = 1'b0;
        set_r(1'b0);
        miss_addr_fifo_full_i = 1'b0;
        tick();
        tick();
        chk("rst_arvalid", mem_arvalid_o, 0);
        chk("rst_ack", miss_ack_o, 0);
        chk("rst_wren", miss_addr_fifo_wren_o, 0);
        chk("rst_araddr", mem_araddr_o, 0);
        chk("rst_out", outstanding_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst_n = 1'b1;
        tick();

        miss_req_i = 1'b1;
        miss_addr_i = 32'h0001_2348;
        mem_arready_i = 1'b1;
        exp_q.push_back(32'h0001_2348);
        chk("idle_arvalid", mem_arvalid_o, 0);
        tick();
        chk("s_arvalid", mem_arvalid_o, 1);
        chk("s_ack", miss_ack_o, 1);
        chk("s_wren", miss_addr_fifo_wren_o, 1);
        chk("s_araddr", mem_araddr_o, 32'h0001_2348);
        chk("s_arlen", mem_arlen_o, 7);
        chk("s_arsize", mem_arsize_o, 3);
        chk("s_arburst", mem_arburst_o, 2);
        chk("s_busy", busy_o, 1);
        tick();
        miss_req_i = 1'b0;
        chk("s_out1", outstanding_o, 1);
        chk("s_arvalid_drop", mem_arvalid_o, 0);
        chk("s_busy_out", busy_o, 1);
        rlast_pulse();
        chk("s_out0", outstanding_o, 0);
        chk("s_busy0", busy_o, 0);

        mem_arready_i = 1'b0;
        miss_req_i = 1'b1;
        miss_addr_i = 32'hABCD_EF17;
        exp_q.push_back(32'hABCD_EF17);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("st_arvalid", mem_arvalid_o, 1);
            chk("st_araddr", mem_araddr_o, 32'hABCD_EF10);
            chk("st_ack", miss_ack_o, 0);
            chk("st_wren", miss_addr_fifo_wren_o, 0);
            chk("st_out", outstanding_o, 0);
            tick();
        end
        mem_arready_i = 1'b1;
        #1;
        chk("st_hs_ack", miss_ack_o, 1);
        tick();
        miss_req_i = 1'b0;
        chk("st_out1", outstanding_o, 1);
        rlast_pulse();
        chk("st_out0", outstanding_o, 0);

        for (int i = 0; i < MAX; i++)
            issue(32'h1000_0000 + 32'(i) * 32'h40);
        chk("lim_out4", outstanding_o, 4);
        miss_req_i = 1'b1;
        miss_addr_i = 32'h2000_0008;
        exp_q.push_back(32'h2000_0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lim_noack", miss_ack_o, 0);
            chk("lim_noar", mem_arvalid_o, 0);
            chk("lim_out", outstanding_o, 4);
        end
        rlast_pulse();
        chk("lim_out3", outstanding_o, 3);
        chk("lim_noar_T", mem_arvalid_o, 0);
        tick();
        chk("lim_ar_T2", mem_arvalid_o, 1);
        chk("lim_ack_T2", miss_ack_o, 1);
        tick();
        miss_req_i = 1'b0;
        chk("lim_out4b", outstanding_o, 4);

        rlast_pulse();
        rlast_pulse();
        chk("sim_out2", outstanding_o, 2);
        miss_req_i = 1'b1;
        miss_addr_i = 32'h3000_0020;
        exp_q.push_back(32'h3000_0020);
        tick();
        set_r(1'b1);
        #1;
        chk("sim_ack", miss_ack_o, 1);
        tick();
        set_r(1'b0);
        miss_req_i = 1'b0;
        chk("sim_out_hold", outstanding_o, 2);
        rlast_pulse();
        rlast_pulse();
        chk("sim_out0", outstanding_o, 0);

        miss_addr_fifo_full_i = 1'b1;
        miss_req_i = 1'b1;
        miss_addr_i = 32'h4000_0030;
        exp_q.push_back(32'h4000_0030);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ff_noar", mem_arvalid_o, 0);
            chk("ff_noack", miss_ack_o, 0);
        end
        miss_addr_fifo_full_i = 1'b0;
        tick();
        chk("ff_ar", mem_arvalid_o, 1);
        chk("ff_ack", miss_ack_o, 1);
        tick();
        miss_req_i = 1'b0;
        chk("ff_out1", outstanding_o, 1);
        rlast_pulse();
        chk("ff_out0", outstanding_o, 0);
        chk("pre_err", err_o, 0);

        rlast_pulse();
        chk("err_set", err_o, 1);
        chk("err_out0", outstanding_o, 0);
        tick();
        tick();
        chk("err_sticky", err_o, 1);

        mem_arready_i = 1'b0;
        miss_req_i = 1'b1;
        miss_addr_i = 32'h5000_0040;
        tick();
        chk("ar_pre_rst", mem_arvalid_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_rst_arvalid", mem_arvalid_o, 0);
        chk("ar_rst_ack", miss_ack_o, 0);
        chk("ar_rst_wren", miss_addr_fifo_wren_o, 0);
        chk("ar_rst_araddr", mem_araddr_o, 0);
        chk("ar_rst_out", outstanding_o, 0);
        chk("ar_rst_busy", busy_o, 0);
        chk("ar_rst_err", err_o, 0);
        miss_req_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_arvalid", mem_arvalid_o, 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
